// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - default widths and FIFO operation encoding for io_bridge
package io_bridge_pkg;

  localparam int DefaultDataWidth = 8;
  localparam int DefaultDepthLog2 = 4;

  // Encoding is {push, pop}, so a raw two-bit concatenation casts straight to it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/io_bridge_sync_fifo.sv
// rtl/io_bridge_sync_fifo.sv - single-clock FIFO with occupancy count and registered head
module sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int WIDTH      = DefaultDataWidth,
  parameter int DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;
  fifo_op_e              op;

  // Count never exceeds the depth, so its top bit alone marks full.
  assign full    = count_q[DEPTH_LOG2];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case (op)
      OP_PUSH: count_d = count_q + 1'b1;
      OP_POP:  count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - host<->CPU byte bridge: input FIFO toward CPU, output FIFO toward host
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_data_available,
  input  logic                  cpu_data_read,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_data_out_en,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  output logic                  out_overflow,
  input  logic                  overflow_clr,
  output logic [DEPTH_LOG2:0]   in_count,
  output logic [DEPTH_LOG2:0]   out_count
);

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop, drop;
  logic out_overflow_q, out_overflow_d;

  // host_in_ready depends only on registered occupancy, never on cpu_data_read.
  assign host_in_ready      = !in_full;
  assign cpu_data_available = !in_empty;
  assign host_out_valid     = !out_empty;
  assign in_push            = host_in_valid && !in_full;
  assign in_pop             = cpu_data_read && !in_empty;
  assign out_pop            = host_out_ready && !out_empty;
  assign out_push           = cpu_data_out_en && (!out_full || out_pop);
  assign drop               = cpu_data_out_en && out_full && !out_pop;
  assign out_overflow       = out_overflow_q;

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_push),
    .push_data (host_in_data),
    .pop       (in_pop),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count),
    .head      (cpu_data_in)
  );

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data (cpu_data_out),
    .pop       (out_pop),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count),
    .head      (host_out_data)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    out_overflow_d = out_overflow_q;
    if (overflow_clr) out_overflow_d = 1'b0;
    if (drop)         out_overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_overflow_q <= 1'b0;
    else        out_overflow_q <= out_overflow_d;
  end

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - directed vector table plus multi-cycle sequences for io_bridge
module tb_io_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cpu_data_in;
  logic       cpu_data_available;
  logic       cpu_data_read;
  logic [7:0] cpu_data_out;
  logic       cpu_data_out_en;
  logic [7:0] host_in_data;
  logic       host_in_valid;
  logic       host_in_ready;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready;
  logic       out_overflow;
  logic       overflow_clr;
  logic [4:0] in_count;
  logic [4:0] out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_bridge #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpu_data_in        (cpu_data_in),
    .cpu_data_available (cpu_data_available),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_out       (cpu_data_out),
    .cpu_data_out_en    (cpu_data_out_en),
    .host_in_data       (host_in_data),
    .host_in_valid      (host_in_valid),
    .host_in_ready      (host_in_ready),
    .host_out_data      (host_out_data),
    .host_out_valid     (host_out_valid),
    .host_out_ready     (host_out_ready),
    .out_overflow       (out_overflow),
    .overflow_clr       (overflow_clr),
    .in_count           (in_count),
    .out_count          (out_count)
  );

  typedef struct {
    logic       rst_n;
    logic       hv;
    logic [7:0] hd;
    logic       rd;
    logic       oen;
    logic [7:0] od;
    logic       hr;
    logic       clr;
    logic       e_av;
    logic [7:0] e_din;
    logic [4:0] e_inc;
    logic       e_hrdy;
    logic       e_ov;
    logic [7:0] e_dout;
    logic [4:0] e_outc;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n           = 1'b1;
    host_in_valid   = 1'b0;
    host_in_data    = 8'h00;
    cpu_data_read   = 1'b0;
    cpu_data_out_en = 1'b0;
    cpu_data_out    = 8'h00;
    host_out_ready  = 1'b0;
    overflow_clr    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic av, input logic [7:0] din,
                              input logic [4:0] inc, input logic hrdy, input logic ov,
                              input logic [7:0] dout, input logic [4:0] outc, input logic ovf);
    chk({tag, ".avail"}, 32'(cpu_data_available), 32'(av));
    if (av) chk({tag, ".cpu_data_in"}, 32'(cpu_data_in), 32'(din));
    chk({tag, ".in_count"}, 32'(in_count), 32'(inc));
    chk({tag, ".host_in_ready"}, 32'(host_in_ready), 32'(hrdy));
    chk({tag, ".host_out_valid"}, 32'(host_out_valid), 32'(ov));
    if (ov) chk({tag, ".host_out_data"}, 32'(host_out_data), 32'(dout));
    chk({tag, ".out_count"}, 32'(out_count), 32'(outc));
    chk({tag, ".out_overflow"}, 32'(out_overflow), 32'(ovf));
  endtask

  initial begin
    //           rst hv  hd     rd   oen  od     hr   clr  | av  din    inc   hrdy ov   dout   outc  ovf
    vecs[0]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 5'd1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 5'd1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 8'h10, 5'd1, 1'b1, 1'b1, 8'h20, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

    idle();
    rst_n = 1'b0;
    step();
    step();

    for (int i = 0; i < 12; i++) begin
      rst_n           = vecs[i].rst_n;
      host_in_valid   = vecs[i].hv;
      host_in_data    = vecs[i].hd;
      cpu_data_read   = vecs[i].rd;
      cpu_data_out_en = vecs[i].oen;
      cpu_data_out    = vecs[i].od;
      host_out_ready  = vecs[i].hr;
      overflow_clr    = vecs[i].clr;
      step();
      expect_state($sformatf("vec%0d", i), vecs[i].e_av, vecs[i].e_din, vecs[i].e_inc,
                   vecs[i].e_hrdy, vecs[i].e_ov, vecs[i].e_dout, vecs[i].e_outc, vecs[i].e_ovf);
    end
    idle();

    // Input FIFO fills to 16, blocks the host, and one CPU read reopens it.
    for (int i = 0; i < 16; i++) begin
      host_in_valid = 1'b1;
      host_in_data  = 8'(8'h80 + i);
      step();
      chk($sformatf("fill_in.count%0d", i), 32'(in_count), 32'(i + 1));
    end
    chk("fill_in.ready_low", 32'(host_in_ready), 32'd0);
    host_in_data = 8'hEE;
    step();
    chk("fill_in.blocked_count", 32'(in_count), 32'd16);
    host_in_valid = 1'b0;
    chk("fill_in.head", 32'(cpu_data_in), 32'h80);
    cpu_data_read = 1'b1;
    step();
    cpu_data_read = 1'b0;
    chk("fill_in.count_after_read", 32'(in_count), 32'd15);
    chk("fill_in.ready_back", 32'(host_in_ready), 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain_in.byte%0d", i), 32'(cpu_data_in), 32'(8'h80 + i));
      cpu_data_read = 1'b1;
      step();
    end
    cpu_data_read = 1'b0;
    chk("drain_in.avail_low", 32'(cpu_data_available), 32'd0);
    chk("drain_in.count_zero", 32'(in_count), 32'd0);

    // Output FIFO: 17 bytes with host stalled drops the last and sets overflow.
    for (int i = 0; i < 17; i++) begin
      cpu_data_out_en = 1'b1;
      cpu_data_out    = 8'(i);
      step();
      if (i == 15) chk("fill_out.ovf_before_drop", 32'(out_overflow), 32'd0);
    end
    cpu_data_out_en = 1'b0;
    chk("fill_out.count", 32'(out_count), 32'd16);
    chk("fill_out.overflow", 32'(out_overflow), 32'd1);

    // Clear together with another drop: set wins; clear alone then takes effect.
    cpu_data_out_en = 1'b1;
    cpu_data_out    = 8'h99;
    overflow_clr    = 1'b1;
    step();
    cpu_data_out_en = 1'b0;
    chk("clr_drop.overflow", 32'(out_overflow), 32'd1);
    chk("clr_drop.count", 32'(out_count), 32'd16);
    step();
    overflow_clr = 1'b0;
    chk("clr_alone.overflow", 32'(out_overflow), 32'd0);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_out.byte%0d", i), 32'(host_out_data), 32'(i));
      host_out_ready = 1'b1;
      step();
    end
    host_out_ready = 1'b0;
    chk("drain_out.valid_low", 32'(host_out_valid), 32'd0);

    // Full output FIFO with a same-cycle host pop accepts the new byte.
    for (int i = 0; i < 16; i++) begin
      cpu_data_out_en = 1'b1;
      cpu_data_out    = 8'(i);
      step();
    end
    cpu_data_out    = 8'h55;
    host_out_ready  = 1'b1;
    step();
    cpu_data_out_en = 1'b0;
    host_out_ready  = 1'b0;
    chk("full_pop.count", 32'(out_count), 32'd16);
    chk("full_pop.overflow", 32'(out_overflow), 32'd0);
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("full_pop.byte%0d", i), 32'(host_out_data), (i == 16) ? 32'h55 : 32'(i));
      host_out_ready = 1'b1;
      step();
    end
    host_out_ready = 1'b0;
    chk("full_pop.empty", 32'(out_count), 32'd0);

    // Reset with five bytes buffered in each direction discards them all.
    for (int i = 0; i < 5; i++) begin
      host_in_valid   = 1'b1;
      host_in_data    = 8'(8'hC0 + i);
      cpu_data_out_en = 1'b1;
      cpu_data_out    = 8'(8'hD0 + i);
      step();
    end
    idle();
    chk("pre_rst.in_count", 32'(in_count), 32'd5);
    chk("pre_rst.out_count", 32'(out_count), 32'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_state("mid_rst", 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0);
    step();
    expect_state("post_rst", 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
